mem_copy_dma: RTL

Single-channel word copy engine that acts as the initiator on the req/gnt/rvalid memory port served by the single-port RAM. Once started, it copies `len_i` words from a source byte address to a destination byte address, moving one word at a time with a strict read-then-write sequence and at most one outstanding transaction. It sits between a control register block and one RAM instance; an optional fill mode writes a constant pattern instead of copying.

---
 rtl/mem_copy_dma.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: single-channel word copy engine, initiator on a req/gnt/rvalid memory port.
// Ports: clk, rst_n (async active-low); start_i/src_addr_i/dst_addr_i/len_i start a transfer;
// busy_o/done_o report status; req_o/addr_o/we_o/wdata_o/be_o drive the memory request;
// gnt_i/rvalid_i/rdata_i carry the memory response.
// Optional fill mode (fill_i, pattern_i) is built only when MEM_COPY_FILL_EN is defined.
module mem_copy_dma #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
`ifdef MEM_COPY_FILL_EN
  input  logic                    fill_i,
  input  logic [DATA_WIDTH-1:0]   pattern_i,
`endif
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    we_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic                    gnt_i,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BYTES);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d, wr_data;
  logic                  fill_go, fill_mode;
`ifdef MEM_COPY_FILL_EN
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  always_comb begin
    fill_d = (state_q == IDLE && start_i) ? fill_i : fill_q;
    pat_d  = (state_q == IDLE && start_i) ? pattern_i : pat_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill_q <= 1'b0;
      pat_q  <= '0;
    end else begin
      fill_q <= fill_d;
      pat_q  <= pat_d;
    end
  assign fill_go   = fill_i;
  assign fill_mode = fill_q;
  assign wr_data   = fill_q ? pat_q : buf_q;
`else
  assign fill_go   = 1'b0;
  assign fill_mode = 1'b0;
  assign wr_data   = buf_q;
`endif
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = (len_i == '0) ? DONE : fill_go ? WR_REQ : RD_REQ;
        src_d   = src_addr_i;
        dst_d   = dst_addr_i;
        rem_d   = len_i;
      end
      RD_REQ:  if (gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (rvalid_i) begin
        buf_d   = rdata_i;
        state_d = WR_REQ;
      end
      WR_REQ:  if (gnt_i) state_d = WR_WAIT;
      // rvalid here is the write acknowledge; the word is complete
      WR_WAIT: if (rvalid_i) begin
        rem_d   = rem_q - LEN_WIDTH'(1);
        src_d   = fill_mode ? src_q : src_q + STEP;
        dst_d   = dst_q + STEP;
        state_d = (rem_q == LEN_WIDTH'(1)) ? DONE : fill_mode ? WR_REQ : RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  // Request fields come only from state and registers, so they hold steady during a stall
  assign busy_o  = state_q != IDLE;
  assign done_o  = state_q == DONE;
  assign req_o   = state_q == RD_REQ || state_q == WR_REQ;
  assign we_o    = state_q == WR_REQ;
  assign addr_o  = (state_q == RD_REQ) ? (src_q & ALIGN) : we_o ? (dst_q & ALIGN) : '0;
  assign wdata_o = we_o ? wr_data : '0;
  assign be_o    = {BYTES{we_o}};
endmodule
